// File: rtl/deframer_i.sv
// rtl/deframer_i.sv - ADAT optical receiver: bit recovery, frame sync and 8x24-bit deserialiser
//
// Purpose: recovers bit timing from an asynchronous NRZI ADAT lightpipe stream,
// finds the frame sync and delivers the eight 24-bit channels plus four user bits
// of each good 256-bit frame into the mclk domain.
//
// Ports:
//   mclk          master clock, all logic on its rising edge
//   rst           synchronous reset, active high
//   adat          raw NRZI ADAT input, asynchronous to mclk
//   chan1..chan8  received samples of the last good frame, held between frames
//   user          user bits of the last good frame
//   frame_stb     one-cycle pulse when chan1..chan8/user have just been updated
//   locked        LOCK_FRAMES consecutive good frames seen, no error/timeout since
//   err           one-cycle pulse on a bad nibble separator
module deframer_i #(
    parameter int BIT_CYCLES  = 8,
    parameter int LOCK_FRAMES = 2,
    parameter int HUNT_LIMIT  = 512
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic        adat,
    output logic [23:0] chan1,
    output logic [23:0] chan2,
    output logic [23:0] chan3,
    output logic [23:0] chan4,
    output logic [23:0] chan5,
    output logic [23:0] chan6,
    output logic [23:0] chan7,
    output logic [23:0] chan8,
    output logic [3:0]  user,
    output logic        frame_stb,
    output logic        locked,
    output logic        err
);

    localparam int PW = $clog2(2 * BIT_CYCLES);
    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam int HW = $clog2(HUNT_LIMIT + 1);

    // First sample half a bit after an edge, then one every BIT_CYCLES.
    // After a repeat sample the counter folds back so it never overflows,
    // no matter how long the input stays quiet.
    localparam logic [PW-1:0] SAMPLE_AT  = PW'(BIT_CYCLES / 2 - 1);
    localparam logic [PW-1:0] SAMPLE_RPT = PW'(BIT_CYCLES / 2 - 1 + BIT_CYCLES);
    localparam logic [PW-1:0] FOLD_TO    = PW'(BIT_CYCLES / 2);
    localparam logic [GW-1:0] GOOD_MAX   = GW'(LOCK_FRAMES);
    localparam logic [HW-1:0] HUNT_LAST  = HW'(HUNT_LIMIT - 1);

    typedef enum logic {HUNT, DATA} state_t;

    logic          sync0, sync1, sync2;
    logic          edge_det;
    logic [PW-1:0] phase;
    logic          edge_seen;
    logic          bit_stb;
    logic          bit_val;

    state_t        state;
    logic [3:0]    zero_run;
    logic [HW-1:0] hunt_bits;
    logic [7:0]    idx;
    logic [2:0]    nib_pos;
    logic [194:0]  shreg;
    logic [GW-1:0] good;
    logic [195:0]  frame_bits;

    always_ff @(posedge mclk) begin
        if (rst) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync0 <= adat;
            sync1 <= sync0;
            sync2 <= sync1;
        end
    end

    assign edge_det = sync1 ^ sync2;
    assign bit_stb  = (phase == SAMPLE_AT) || (phase == SAMPLE_RPT);
    // NRZI: a transition anywhere in the bit cell makes it a 1.
    assign bit_val  = edge_seen;

    always_ff @(posedge mclk) begin
        if (rst) begin
            phase     <= '0;
            edge_seen <= 1'b0;
        end else begin
            if (edge_det) begin
                phase <= '0;
            end else if (phase == SAMPLE_RPT) begin
                phase <= FOLD_TO;
            end else begin
                phase <= phase + 1'b1;
            end
            // An edge landing on a sample point belongs to the next bit cell.
            if (edge_det) begin
                edge_seen <= 1'b1;
            end else if (bit_stb) begin
                edge_seen <= 1'b0;
            end
        end
    end

    // Completed payload: user bits followed by chan1..chan8, MSB first.
    assign frame_bits = {shreg, bit_val};

    always_ff @(posedge mclk) begin
        if (rst) begin
            state     <= HUNT;
            zero_run  <= '0;
            hunt_bits <= '0;
            idx       <= '0;
            nib_pos   <= '0;
            shreg     <= '0;
            good      <= '0;
            chan1     <= '0;
            chan2     <= '0;
            chan3     <= '0;
            chan4     <= '0;
            chan5     <= '0;
            chan6     <= '0;
            chan7     <= '0;
            chan8     <= '0;
            user      <= '0;
            frame_stb <= 1'b0;
            locked    <= 1'b0;
            err       <= 1'b0;
        end else begin
            frame_stb <= 1'b0;
            err       <= 1'b0;
            if (bit_stb) begin
                unique case (state)
                    HUNT: begin
                        if (hunt_bits == HUNT_LAST) begin
                            locked <= 1'b0;
                            good   <= '0;
                        end else begin
                            hunt_bits <= hunt_bits + 1'b1;
                        end
                        if (bit_val) begin
                            zero_run <= '0;
                            if (zero_run >= 4'd10) begin
                                state     <= DATA;
                                idx       <= '0;
                                nib_pos   <= '0;
                                hunt_bits <= '0;
                            end
                        end else if (zero_run != 4'd15) begin
                            zero_run <= zero_run + 1'b1;
                        end
                    end
                    DATA: begin
                        if (nib_pos == 3'd0 && !bit_val) begin
                            err      <= 1'b1;
                            good     <= '0;
                            locked   <= 1'b0;
                            state    <= HUNT;
                            zero_run <= '0;
                        end else begin
                            if (nib_pos != 3'd0) begin
                                shreg <= {shreg[193:0], bit_val};
                            end
                            if (idx == 8'd244) begin
                                user      <= frame_bits[195:192];
                                chan1     <= frame_bits[191:168];
                                chan2     <= frame_bits[167:144];
                                chan3     <= frame_bits[143:120];
                                chan4     <= frame_bits[119:96];
                                chan5     <= frame_bits[95:72];
                                chan6     <= frame_bits[71:48];
                                chan7     <= frame_bits[47:24];
                                chan8     <= frame_bits[23:0];
                                frame_stb <= 1'b1;
                                state     <= HUNT;
                                zero_run  <= '0;
                                if (good < GOOD_MAX) begin
                                    good <= good + 1'b1;
                                end
                                if (good >= GOOD_MAX - 1'b1) begin
                                    locked <= 1'b1;
                                end
                            end
                            idx     <= idx + 8'd1;
                            nib_pos <= (nib_pos == 3'd4) ? 3'd0 : nib_pos + 3'd1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_deframer_i.sv
// tb/tb_deframer_i.sv - scoreboard bench for deframer_i
module tb_deframer_i;

    logic        mclk = 1'b0;
    logic        rst  = 1'b1;
    logic        adat = 1'b0;
    logic [23:0] chan1, chan2, chan3, chan4, chan5, chan6, chan7, chan8;
    logic [3:0]  user;
    logic        frame_stb, locked, err;

    deframer_i #(
        .BIT_CYCLES (8),
        .LOCK_FRAMES(2),
        .HUNT_LIMIT (512)
    ) dut (
        .mclk     (mclk),
        .rst      (rst),
        .adat     (adat),
        .chan1    (chan1),
        .chan2    (chan2),
        .chan3    (chan3),
        .chan4    (chan4),
        .chan5    (chan5),
        .chan6    (chan6),
        .chan7    (chan7),
        .chan8    (chan8),
        .user     (user),
        .frame_stb(frame_stb),
        .locked   (locked),
        .err      (err)
    );

    always #5 mclk = ~mclk;

    typedef struct packed {
        logic [191:0] ch;
        logic [3:0]   u;
        logic         lk;
    } exp_t;

    exp_t sb[$];
    int   stb_times[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   tx_time  = 0;
    int   t_nom    = 0;
    int   off      = 0;
    int   bit_no   = 0;
    bit   jit_mode = 1'b0;
    int   exp_good = 0;
    int   push_cnt = 0;
    int   stb_cnt  = 0;
    int   err_cnt  = 0;
    int   mon_cyc  = 0;

    logic [191:0] std_ch = {24'h10A5C3, 24'h20A5C3, 24'h30A5C3, 24'h40A5C3,
                            24'h50A5C3, 24'h60A5C3, 24'h70A5C3, 24'h80A5C3};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge mclk) begin : monitor
        exp_t         e;
        logic [191:0] got_ch;
        mon_cyc++;
        if (err === 1'b1) err_cnt++;
        if (frame_stb === 1'b1) begin
            stb_cnt++;
            stb_times.push_back(mon_cyc);
            check_eq("stb_has_expected_frame", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e      = sb.pop_front();
                got_ch = {chan1, chan2, chan3, chan4, chan5, chan6, chan7, chan8};
                for (int c = 0; c < 8; c++) begin
                    check_eq($sformatf("chan%0d", c + 1), 32'(got_ch[191 - 24 * c -: 24]),
                             32'(e.ch[191 - 24 * c -: 24]));
                end
                check_eq("user", 32'(user), 32'(e.u));
                check_eq("locked_at_stb", 32'(locked), 32'(e.lk));
            end
        end
    end

    task automatic tick();
        @(posedge mclk);
        #1;
        tx_time++;
    endtask

    task automatic start_stream();
        t_nom = tx_time + 16;
        off   = 0;
    endtask

    // Bit cells are 8 mclk, or alternate 7/9 mclk with an edge offset that
    // wanders by at most one mclk per edge inside +/-3 mclk.
    task automatic send_bit(input bit b);
        int dur;
        int target;
        dur = jit_mode ? ((bit_no % 2 == 1) ? 9 : 7) : 8;
        if (b) begin
            if (jit_mode) begin
                off = off + int'($urandom_range(0, 2)) - 1;
                if (off > 3) off = 3;
                if (off < -3) off = -3;
            end
            target = t_nom + off;
            while (tx_time < target) tick();
            adat = ~adat;
        end
        t_nom  += dur;
        bit_no++;
    endtask

    task automatic send_frame(input logic [191:0] chs, input logic [3:0] u,
                              input int bad_sep, input int abort_at);
        bit   fb[$];
        exp_t e;
        fb = {};
        for (int i = 0; i < 10; i++) fb.push_back(1'b0);
        fb.push_back(1'b1);
        fb.push_back(1'b1);
        for (int i = 3; i >= 0; i--) fb.push_back(u[i]);
        for (int j = 191; j >= 0; j--) begin
            if ((191 - j) % 4 == 0) fb.push_back(1'b1);
            fb.push_back(chs[j]);
        end
        if (bad_sep >= 0) fb[11 + bad_sep] = 1'b0;
        if (bad_sep < 0 && abort_at < 0) begin
            if (exp_good < 2) exp_good++;
            e.ch = chs;
            e.u  = u;
            e.lk = (exp_good >= 2);
            sb.push_back(e);
            push_cnt++;
        end else if (bad_sep >= 0) begin
            exp_good = 0;
        end
        for (int k = 0; k < 256; k++) begin
            if (k == abort_at) begin
                rst = 1'b1;
                repeat (3) tick();
                rst = 1'b0;
                exp_good = 0;
                check_eq("midrst_chan1", 32'(chan1), 32'd0);
                check_eq("midrst_chan8", 32'(chan8), 32'd0);
                check_eq("midrst_user", 32'(user), 32'd0);
                check_eq("midrst_locked", 32'(locked), 32'd0);
                check_eq("midrst_stb", 32'(frame_stb), 32'd0);
                check_eq("midrst_pending", 32'(sb.size()), 32'd0);
            end
            send_bit(fb[k]);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst  = 1'b1;
        adat = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
        check_eq("rst_chan1", 32'(chan1), 32'd0);
        check_eq("rst_chan8", 32'(chan8), 32'd0);
        check_eq("rst_user", 32'(user), 32'd0);
        check_eq("rst_stb", 32'(frame_stb), 32'd0);
        check_eq("rst_locked", 32'(locked), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);

        // Clean stream, then a broken separator before chan3 nibble 2 in frame 5.
        jit_mode = 1'b0;
        start_stream();
        stb_times = {};
        for (int f = 0; f < 4; f++) send_frame(std_ch, 4'hA, -1, -1);
        send_frame(std_ch, 4'hA, 70, -1);
        check_eq("clean_stb_count", 32'(stb_times.size()), 32'd4);
        if (stb_times.size() >= 4) begin
            for (int i = 1; i < 4; i++) begin
                check_eq("stb_spacing", 32'(stb_times[i] - stb_times[i-1]), 32'd2048);
            end
        end
        check_eq("err_after_bad_sep", 32'(err_cnt), 32'd1);
        check_eq("locked_after_bad_sep", 32'(locked), 32'd0);
        send_frame(std_ch, 4'hA, -1, -1);
        send_frame(std_ch, 4'hA, -1, -1);

        // Quiet input: lock survives below the hunt limit, drops beyond it.
        repeat (400 * 8) tick();
        check_eq("locked_before_hunt_limit", 32'(locked), 32'd1);
        repeat (200 * 8) tick();
        check_eq("locked_after_hunt_limit", 32'(locked), 32'd0);
        check_eq("no_err_on_timeout", 32'(err_cnt), 32'd1);
        exp_good = 0;

        // 7/9 mclk bit cells with wandering edge offset, random payloads.
        jit_mode = 1'b1;
        start_stream();
        for (int f = 0; f < 6; f++) begin
            send_frame({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()},
                       4'($urandom()), -1, -1);
        end
        jit_mode = 1'b0;
        start_stream();

        // All-ones and all-zeros payloads.
        send_frame({8{24'hFFFFFF}}, 4'hF, -1, -1);
        send_frame({8{24'h000000}}, 4'h0, -1, -1);
        send_frame({8{24'hFFFFFF}}, 4'hF, -1, -1);

        // Reset in the middle of a frame discards it; relock takes two frames.
        send_frame(std_ch, 4'hA, -1, 100);
        send_frame(std_ch, 4'hA, -1, -1);
        send_frame(std_ch, 4'hA, -1, -1);

        repeat (64) tick();
        check_eq("final_pending", 32'(sb.size()), 32'd0);
        check_eq("final_stb_count", 32'(stb_cnt), 32'(push_cnt));
        check_eq("final_err_count", 32'(err_cnt), 32'd1);
        check_eq("final_locked", 32'(locked), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
